// File: rtl/lsu_mem_stage.sv
// RV32 load/store memory stage: one DMEM word request per op,
// lane steering for stores, alignment and extension for loads.
module lsu_mem_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [2:0]                req_funct3_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [4:0]                req_rd_i,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
    output logic [DATA_WIDTH/8-1:0]   dmem_be_o,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
    input  logic                      dmem_gnt_i,
    input  logic                      dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic [4:0]                rsp_rd_o,
    output logic                      rsp_fault_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_we;
    logic [2:0]              r_funct3;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [4:0]              r_rd;
    logic                    r_fault;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_accept;
    logic                    w_fault;
    logic                    w_req;
    logic [DATA_WIDTH/8-1:0] w_be;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_byte_sh;
    logic [DATA_WIDTH-1:0]   w_half_sh;
    logic [DATA_WIDTH-1:0]   w_ext;

    assign w_accept = req_valid_i & req_ready_o;

    always_comb begin
        w_fault = 1'b0;
        if (req_we_i) begin
            unique case (req_funct3_i)
                3'd0:    w_fault = 1'b0;
                3'd1:    w_fault = req_addr_i[0];
                3'd2:    w_fault = |req_addr_i[1:0];
                default: w_fault = 1'b1;
            endcase
        end else begin
            unique case (req_funct3_i)
                3'd0,
                3'd4:    w_fault = 1'b0;
                3'd1,
                3'd5:    w_fault = req_addr_i[0];
                3'd2:    w_fault = |req_addr_i[1:0];
                default: w_fault = 1'b1;
            endcase
        end
    end

    // Loads share the store byte-enable pattern; funct3[1:0] gives the size.
    always_comb begin
        w_be    = 4'hF;
        w_wdata = r_wdata;
        unique case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {r_addr[1], 1'b0};
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = r_wdata;
            end
        endcase
    end

    assign w_byte_sh = dmem_rdata_i >> {r_addr[1:0], 3'b000};
    assign w_half_sh = dmem_rdata_i >> {r_addr[1], 4'b0000};

    always_comb begin
        w_ext = dmem_rdata_i;
        unique case (r_funct3)
            3'd0:    w_ext = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            3'd1:    w_ext = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            3'd4:    w_ext = {24'd0, w_byte_sh[7:0]};
            3'd5:    w_ext = {16'd0, w_half_sh[15:0]};
            default: w_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_fault ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    w_next = r_we ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= 5'd0;
            r_fault  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= req_we_i;
                r_funct3 <= req_funct3_i;
                r_addr   <= req_addr_i;
                r_wdata  <= req_wdata_i;
                r_rd     <= req_rd_i;
                r_fault  <= w_fault;
                r_rdata  <= '0;
            end else if (r_state == S_WAIT && dmem_rvalid_i) begin
                r_rdata <= w_ext;
            end
        end
    end

    assign w_req        = (r_state == S_REQ);
    assign req_ready_o  = (r_state == S_IDLE);
    assign dmem_req_o   = w_req;
    assign dmem_we_o    = w_req & r_we;
    assign dmem_addr_o  = w_req ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dmem_be_o    = w_req ? w_be : '0;
    assign dmem_wdata_o = (w_req & r_we) ? w_wdata : '0;
    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_rdata_o  = r_rdata;
    assign rsp_rd_o     = r_rd;
    assign rsp_fault_o  = r_fault;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: load/store lanes, faults,
// handshake stalls and reset during an outstanding load.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rstn;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_fault_o;

    int n_chk;
    int n_bad;

    lsu_mem_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_funct3_i  (req_funct3_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_rd_i      (req_rd_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_rd_o      (rsp_rd_o),
        .rsp_fault_o   (rsp_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full op with immediate gnt and next-cycle rvalid.
    task automatic op(input string tag, input logic we,
                      input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd,
                      input logic [31:0] rdata, input logic [3:0] e_be,
                      input logic [31:0] e_wdata,
                      input logic [31:0] e_rdata, input logic e_fault);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_rd_i     = rd;
        chk({tag, ".ready"}, {31'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        if (e_fault) begin
            chk({tag, ".noreq"}, {31'd0, dmem_req_o}, 32'd0);
            chk({tag, ".fvalid"}, {31'd0, rsp_valid_o}, 32'd1);
            chk({tag, ".fault"}, {31'd0, rsp_fault_o}, 32'd1);
            chk({tag, ".fdata"}, rsp_rdata_o, 32'd0);
        end else begin
            chk({tag, ".req"}, {31'd0, dmem_req_o}, 32'd1);
            chk({tag, ".we"}, {31'd0, dmem_we_o}, {31'd0, we});
            chk({tag, ".addr"}, dmem_addr_o, {addr[31:2], 2'b00});
            chk({tag, ".be"}, {28'd0, dmem_be_o}, {28'd0, e_be});
            if (we) chk({tag, ".wdata"}, dmem_wdata_o, e_wdata);
            dmem_gnt_i = 1'b1;
            tick();
            dmem_gnt_i = 1'b0;
            chk({tag, ".req_off"}, {31'd0, dmem_req_o}, 32'd0);
            if (!we) begin
                chk({tag, ".t2"}, {31'd0, rsp_valid_o}, 32'd0);
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rdata;
                tick();
                dmem_rvalid_i = 1'b0;
            end
            chk({tag, ".valid"}, {31'd0, rsp_valid_o}, 32'd1);
            chk({tag, ".nofault"}, {31'd0, rsp_fault_o}, 32'd0);
            chk({tag, ".rdata"}, rsp_rdata_o, e_rdata);
        end
        chk({tag, ".rd"}, {27'd0, rsp_rd_o}, {27'd0, rd});
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk({tag, ".done"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, ".idle"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rstn = 1'b0;
        req_valid_i = 1'b0;
        req_we_i = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i = 32'd0;
        req_wdata_i = 32'd0;
        req_rd_i = 5'd0;
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i = 32'd0;
        rsp_ready_i = 1'b0;
        #12;
        chk("rst.ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst.req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst.valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst.rdata", rsp_rdata_o, 32'd0);
        chk("rst.addr", dmem_addr_o, 32'd0);
        rstn = 1'b1;
        tick();

        op("lw", 1'b0, 3'd2, 32'h100, 32'd0, 5'd7, 32'hDEADBEEF,
           4'hF, 32'd0, 32'hDEADBEEF, 1'b0);
        op("lb", 1'b0, 3'd0, 32'h103, 32'd0, 5'd3, 32'h80123456,
           4'b1000, 32'd0, 32'hFFFFFF80, 1'b0);
        op("lbu", 1'b0, 3'd4, 32'h103, 32'd0, 5'd4, 32'h80123456,
           4'b1000, 32'd0, 32'h00000080, 1'b0);
        op("lhu", 1'b0, 3'd5, 32'h102, 32'd0, 5'd5, 32'h80123456,
           4'b1100, 32'd0, 32'h00008012, 1'b0);
        op("lh0", 1'b0, 3'd1, 32'h100, 32'd0, 5'd6, 32'h1234F00D,
           4'b0011, 32'd0, 32'hFFFFF00D, 1'b0);
        op("sb", 1'b1, 3'd0, 32'h201, 32'h000000AB, 5'd1, 32'd0,
           4'b0010, 32'hABABABAB, 32'd0, 1'b0);
        op("sh", 1'b1, 3'd1, 32'h202, 32'h0000CAFE, 5'd2, 32'd0,
           4'b1100, 32'hCAFECAFE, 32'd0, 1'b0);
        op("sw", 1'b1, 3'd2, 32'h300, 32'h11223344, 5'd8, 32'd0,
           4'hF, 32'h11223344, 32'd0, 1'b0);
        op("lwmis", 1'b0, 3'd2, 32'h102, 32'd0, 5'd9, 32'd0,
           4'h0, 32'd0, 32'd0, 1'b1);
        op("lhmis", 1'b0, 3'd1, 32'h101, 32'd0, 5'd10, 32'd0,
           4'h0, 32'd0, 32'd0, 1'b1);
        op("ld3", 1'b0, 3'd3, 32'h100, 32'd0, 5'd11, 32'd0,
           4'h0, 32'd0, 32'd0, 1'b1);
        op("s3", 1'b1, 3'd3, 32'h100, 32'd0, 5'd12, 32'd0,
           4'h0, 32'd0, 32'd0, 1'b1);

        // LH at 0x202, gnt held off 3 cycles, response held 2 cycles.
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd1;
        req_addr_i   = 32'h202;
        req_rd_i     = 5'd13;
        tick();
        req_addr_i = 32'h400;
        req_rd_i   = 5'd20;
        for (int i = 0; i < 3; i++) begin
            chk("stall.req", {31'd0, dmem_req_o}, 32'd1);
            chk("stall.addr", dmem_addr_o, 32'h200);
            chk("stall.be", {28'd0, dmem_be_o}, 32'hC);
            chk("stall.busy", {31'd0, req_ready_o}, 32'd0);
            tick();
        end
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h80123456;
        tick();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        for (int i = 0; i < 2; i++) begin
            chk("hold.valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("hold.rdata", rsp_rdata_o, 32'hFFFF8012);
            chk("hold.rd", {27'd0, rsp_rd_o}, 32'd13);
            chk("hold.busy", {31'd0, req_ready_o}, 32'd0);
            tick();
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("hold.idle", {31'd0, req_ready_o}, 32'd1);
        chk("hold.noacc", {31'd0, dmem_req_o}, 32'd0);

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        req_valid_i  = 1'b1;
        req_funct3_i = 3'd2;
        req_addr_i   = 32'h500;
        req_rd_i     = 5'd14;
        tick();
        req_valid_i = 1'b0;
        dmem_gnt_i  = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        chk("wait.busy", {31'd0, req_ready_o}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("mrst.ready", {31'd0, req_ready_o}, 32'd1);
        chk("mrst.req", {31'd0, dmem_req_o}, 32'd0);
        chk("mrst.rd", {27'd0, rsp_rd_o}, 32'd0);
        tick();
        rstn = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFEF00D;
        tick();
        dmem_rvalid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("late.valid", {31'd0, rsp_valid_o}, 32'd0);
            chk("late.ready", {31'd0, req_ready_o}, 32'd1);
            chk("late.rdata", rsp_rdata_o, 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0x%08h exp=0x%08h", 32'd0, 32'd1);
        $fatal(1, "timeout");
    end

endmodule
